// File: rtl/comparator_serial.sv
// Bit-serial unsigned magnitude comparator (MSB first) with start/done handshake.
// Optional macro EARLY_EXIT_EN: finish as soon as the first differing bit is seen.
module comparator_serial #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         smaller,
  output logic         equal,
  output logic         greater,
  output logic [1:0]   dbg_state
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  sh_a;
  logic [N-1:0]  sh_b;
  logic [CW-1:0] cnt;
  logic          decided;
  logic          gt;
  logic          bit_diff;
  logic          decided_nxt;
  logic          gt_nxt;
  logic          finish;

  // Handshake: start is sampled only while idle (busy=0); once taken, busy stays
  // high until and including the single done cycle, when the flags become valid.
  always_comb begin
    state_nxt   = state;
    bit_diff    = sh_a[N-1] ^ sh_b[N-1];
    decided_nxt = decided | bit_diff;
    gt_nxt      = decided ? gt : sh_a[N-1];
`ifdef EARLY_EXIT_EN
    finish      = (cnt == '0) || (!decided && bit_diff);
`else
    finish      = (cnt == '0);
`endif
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (finish) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy      = (state != IDLE);
    done      = (state == DONE);
    dbg_state = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sh_a    <= '0;
      sh_b    <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      gt      <= 1'b0;
      smaller <= 1'b0;
      equal   <= 1'b0;
      greater <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            sh_a    <= a;
            sh_b    <= b;
            cnt     <= CW'(N - 1);
            decided <= 1'b0;
            gt      <= 1'b0;
          end
        end
        SHIFT: begin
          sh_a    <= sh_a << 1;
          sh_b    <= sh_b << 1;
          cnt     <= cnt - CW'(1);
          decided <= decided_nxt;
          gt      <= gt_nxt;
          // Flags are loaded on the edge into DONE so they read valid during done.
          if (finish) begin
            greater <= decided_nxt & gt_nxt;
            smaller <= decided_nxt & ~gt_nxt;
            equal   <= ~decided_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_serial.sv
// Self-checking bench for comparator_serial: edge-level behavioural model plus
// per-cycle output compare, directed scenarios and randomized compares.
module tb_comparator_serial;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy, done, smaller, equal, greater;
  logic [1:0]   dbg_state;

  int checks = 0;
  int failures = 0;

  comparator_serial #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .smaller(smaller), .equal(equal),
    .greater(greater), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // edge_cnt counts rising edges; "period c" is the time after edge c.
  int         edge_cnt = 0;
  bit         active = 1'b0;
  int         acc_edge = 0;
  int         done_edge = 0;
  int         accepts = 0;
  logic [2:0] pend_flags = '0;   // {lt, eq, gt}
  logic [2:0] exp_flags = '0;

  // Edges from acceptance until done is visible.
  function automatic int latency(input logic [N-1:0] x, input logic [N-1:0] y);
`ifdef EARLY_EXIT_EN
    for (int i = N - 1; i >= 0; i--)
      if (x[i] != y[i]) return N - i;
`endif
    return N;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    = 1'b0;
      exp_flags = '0;
    end else begin
      edge_cnt++;
      if (active && edge_cnt == done_edge) exp_flags = pend_flags;
      if (start && (!active || edge_cnt >= done_edge + 2)) begin
        active     = 1'b1;
        acc_edge   = edge_cnt;
        done_edge  = edge_cnt + latency(a, b);
        pend_flags = {a < b, a == b, a > b};
        accepts++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int         done_count = 0;
  int         done_edges[$];
  logic [2:0] done_flags[$];
  logic       exp_busy, exp_done;
  logic [4:0] exp_v, act_v;

  always @(negedge clk) begin
    exp_busy = active && edge_cnt >= acc_edge && edge_cnt <= done_edge;
    exp_done = active && edge_cnt == done_edge;
    exp_v    = {exp_busy, exp_done, exp_flags};
    act_v    = {busy, done, smaller, equal, greater};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL outputs edge=%0d busy/done/lt/eq/gt got=%b expected=%b", edge_cnt, act_v, exp_v);
    end
    if (done === 1'b1) begin
      done_count++;
      done_edges.push_back(edge_cnt);
      done_flags.push_back({smaller, equal, greater});
    end
  end

  // ---------------- driver / helper tasks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y);
    @(negedge clk);
    start = 1'b1; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!active || edge_cnt >= done_edge + 1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL wait_idle timeout got=busy expected=idle");
    end
  endtask

  task automatic run(input logic [N-1:0] x, input logic [N-1:0] y);
    issue(x, y);
    wait_idle();
  endtask

  // ---------------- stimulus ----------------
  int         base;
  logic [N-1:0] x, y, one;
  int         mode;

  initial begin
    one = 1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, smaller, equal, greater, dbg_state}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 80 vs 7F: MSB decides, greater
    run(8'h80, 8'h7F);
`ifdef EARLY_EXIT_EN
    check("t1_done_cycle", done_edges[$] - acc_edge + 1, 2);
`else
    check("t1_done_cycle", done_edges[$] - acc_edge + 1, 9);
`endif
    check("t1_flags_at_done", done_flags[$], 3'b001);
    check("t1_flags_hold", {smaller, equal, greater}, 3'b001);

    // equal operands take the full width in both builds
    run(8'hA5, 8'hA5);
    check("t2_done_cycle", done_edges[$] - acc_edge + 1, 9);
    check("t2_flags_at_done", done_flags[$], 3'b010);

    // back-to-back: start held high, second compare taken on first idle cycle
    base = accepts;
    @(negedge clk);
    start = 1'b1; a = 8'h00; b = 8'hFF;
    @(negedge clk);
    a = 8'h3C; b = 8'h3D;
    for (int i = 0; i < 40 && accepts < base + 2; i++) @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("t3_accepts", accepts - base, 2);
    // fixed build: 8+2; early build: 1+2 then 8, also 10 apart
    check("t3_done_spacing", done_edges[$] - done_edges[$-1], 10);
    check("t3_flags", {done_flags[$-1], done_flags[$]}, 6'b100_100);

    // start while busy is ignored
    base = done_count;
    issue(8'h01, 8'h02);
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'h00;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("t4_done_pulses", done_count - base, 1);
    check("t4_flags", done_flags[$], 3'b100);

    // reset mid-compare aborts
    base = done_count;
    issue(8'hF0, 8'h0F);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("t5_reset_outputs", {busy, done, smaller, equal, greater}, 32'h0);
`ifdef EARLY_EXIT_EN
    check("t5_done_pulses", done_count - base, 1);
`else
    check("t5_done_pulses", done_count - base, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(8'h12, 8'h34);
    check("t5_after_reset_flags", done_flags[$], 3'b100);

    // randomized compares with spurious starts while busy
    for (int i = 0; i < 2000; i++) begin
      x = N'($urandom);
      mode = $urandom_range(0, 3);
      if (mode == 0) y = x;
      else if (mode == 1) y = x ^ (one << $urandom_range(0, N - 1));
      else y = N'($urandom);
      issue(x, y);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        start = ($urandom_range(0, 3) == 0);
        a = N'($urandom);
        b = N'($urandom);
      end
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
